mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for a single-ported unified 16-bit memory shared by the instruction-fetch stage and the data-memory stage of the pipelined processor. Accepts one outstanding access at a time and gives fixed priority to the data port. Drives the memory's enable, write and address lines for a parameterised access latency, then returns read data with a one-cycle done pulse. Emits stall signals that the hazard logic uses to freeze the fetch and memory stages.

## Interface
- LAT, 2: memory access latency in cycles, from the mem_en cycle to valid mem_rdata; legal range 1..15.
- AW, 16: address width.
- DW, 16: data width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held high until if_done.
- if_addr  in  AW  fetch address; held stable while if_req is high.
- if_rdata  out  DW  instruction word; valid only when if_done is high.
- if_done  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  fetch must hold.
- dm_rd  in  1  data read request; held until dm_done.
- dm_wr  in  1  data write request; held until dm_done.
- dm_addr  in  AW  data address; held stable while a request is high.
- dm_wdata  in  DW  data to write; held stable while dm_wr is high.
- dm_rdata  out  DW  data read result; valid only when dm_done is high.
- dm_done  out  1  one-cycle completion pulse for the data port.
- dm_stall  out  1  memory stage must hold.
- halt  in  1  processor halting; blocks new fetch grants.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_wr  out  1  write qualifier, valid with mem_en.
- mem_addr  out  AW  registered access address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_en.
- err  out  1  sticky protocol error.

## Operation
- FSM states:
  - IDLE.
  - ISSUE: mem_en high for exactly this cycle.
  - WAIT: counts LAT-1 cycles; skipped when LAT=1.
  - RESP: done pulse.
  - RESP always returns to IDLE.
- Arbitration in IDLE only:
  - dm_rd or dm_wr present: grant data. Fixed priority.
  - Otherwise if_req present and halt low: grant fetch.
  - Otherwise remain in IDLE.
- Registered on grant: owner bit, mem_addr, mem_wdata, and mem_wr (which is 1 only for a data write).
- Simultaneous dm_rd and dm_wr: treat as a write, and set err.
- RESP behaviour:
  - The owner's done signal is high and its rdata equals mem_rdata passed through combinationally.
  - The non-owner's done stays 0.
  - A write's RESP also pulses dm_done; dm_rdata is don't-care.
- if_stall = if_req & ~if_done. dm_stall = (dm_rd|dm_wr) & ~dm_done.
- halt: an in-flight fetch completes normally. Data requests are still served while halt is high.
- A request seen in the cycle after RESP (requester not yet deasserted) is treated as a new request. Requesters must drop req in the cycle after done.

## Timing
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - mem_en, mem_wr, if_done, dm_done and err are 0.
  - mem_addr and mem_wdata are 0.
  - An in-flight access is abandoned, with no done pulse.
- Request at cycle 0 in IDLE:
  - mem_en at cycle 1.
  - done at cycle 1+LAT.
  - IDLE again at cycle 2+LAT.
- Throughput is one access per LAT+2 cycles.
- The latency counter is 4 bits, loaded with LAT-1 in ISSUE and decremented in WAIT. It never wraps: exit occurs on a count of 0.

## Configuration
- MEM_ARB_CHECK_EN defined: the checker is instantiated. It sets err, sticky until reset, on any of:
  - dm_rd & dm_wr both high;
  - the granted request dropped before done;
  - the granted address changing before done;
  - the granted address with bit 0 = 1 (unaligned word).
- MEM_ARB_CHECK_EN undefined: err tied to 0 and no checker logic exists. Functional behaviour is otherwise identical.

## Structure
- Shared package mem_arb_pkg holds:
  - FSM state encoding (IDLE/ISSUE/WAIT/RESP, 2 bits);
  - owner encoding (OWN_IF=0, OWN_DM=1);
  - counter width constant LAT_W=4.
- Sub-module mem_arb_chk: the protocol checker, taking the request and grant signals and producing err. It is instantiated only under MEM_ARB_CHECK_EN.

## Test plan
- Fetch read, LAT=2: if_req=1, if_addr=0x0010, memory returns 0xA5A5. Required: mem_en at cycle 1 with mem_addr=0x0010, mem_wr=0; if_done=1 and if_rdata=0xA5A5 at cycle 3; if_stall high during cycles 0–2.
- Simultaneous requests: if_req and dm_rd both at cycle 0, dm_addr=0x0100. Required: data granted first with mem_addr=0x0100. Fetch is then issued at cycle 5 (LAT=2), and if_stall stays high throughout.
- Data write, LAT=3: dm_wr=1, dm_addr=0x0020, dm_wdata=0x1234. Required: mem_en=1, mem_wr=1, mem_wdata=0x1234 at cycle 1; dm_done at cycle 4; if_done stays 0.
- Halt gating: halt=1 with if_req=1 in IDLE. Required: no mem_en for 10 cycles and if_stall=1. A dm_rd raised meanwhile is still served.
- Reset mid-access: rst low during WAIT. Required: outputs 0 immediately and no done pulse. After release, a pending if_req is granted from IDLE.
- Checker (MEM_ARB_CHECK_EN): dm_rd=dm_wr=1 → err=1 from the next cycle until reset. Setting dm_addr=0x0003 also sets err. With the macro undefined, err stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter and its protocol checker.
package mem_arb_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_chk.sv
// Protocol checker for the memory arbiter: raises a sticky err on requester
// misbehaviour (dual rd/wr, dropped or moving request, unaligned address).
module mem_arb_chk
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dmRd,
  input  logic          dmWr,
  input  logic          ifReq,
  input  logic [AW-1:0] ifAddr,
  input  logic [AW-1:0] dmAddr,
  input  logic          busy,
  input  owner_e        owner,
  input  logic [AW-1:0] grantAddr,
  output logic          err
);

  logic          reqHeld;
  logic [AW-1:0] reqAddr;
  logic          violation;

  assign reqHeld = (owner == OWN_DM) ? (dmRd | dmWr) : ifReq;
  assign reqAddr = (owner == OWN_DM) ? dmAddr : ifAddr;

  // Granted request must stay asserted, stable and word-aligned until done.
  assign violation = (dmRd & dmWr)
                   | (busy & (~reqHeld | (reqAddr != grantAddr) | grantAddr[0]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (violation) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter/sequencer for the shared memory.
// Define MEM_ARB_CHECK_EN to instantiate the protocol checker driving err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  input  logic          halt,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  arbState_e        state;
  arbState_e        stateNext;
  owner_e           owner;
  owner_e           grantOwner;
  logic             grant;
  logic             dmReq;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] cntDec;

  assign dmReq  = dm_rd | dm_wr;
  assign cntDec = cnt - LAT_W'(1);

  // Next-state and grant decode; arbitration happens only in IDLE.
  always_comb begin
    stateNext  = state;
    grant      = 1'b0;
    grantOwner = OWN_IF;
    case (state)
      IDLE: begin
        if (dmReq) begin
          grant      = 1'b1;
          grantOwner = OWN_DM;
          stateNext  = ISSUE;
        end else if (if_req && !halt) begin
          grant      = 1'b1;
          grantOwner = OWN_IF;
          stateNext  = ISSUE;
        end
      end
      ISSUE:   stateNext = (LAT == 1) ? RESP : WAIT;
      WAIT:    if (cntDec == '0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Latency counter: holds the remaining WAIT cycles, exits when it reaches 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= LAT_W'(LAT - 1);
    end else if (state == WAIT) begin
      cnt <= cntDec;
    end
  end

  // Access descriptor captured on grant; a dual rd/wr request is a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_IF;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
    end else if (grant) begin
      owner     <= grantOwner;
      mem_addr  <= (grantOwner == OWN_DM) ? dm_addr : if_addr;
      mem_wdata <= (grantOwner == OWN_DM) ? dm_wdata : '0;
      mem_wr    <= (grantOwner == OWN_DM) && dm_wr;
    end
  end

  // Strobes registered from the next state so they align with ISSUE/RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
    end else begin
      mem_en  <= (stateNext == ISSUE);
      if_done <= (stateNext == RESP) && (owner == OWN_IF);
      dm_done <= (stateNext == RESP) && (owner == OWN_DM);
    end
  end

  assign if_rdata = if_done ? mem_rdata : '0;
  assign dm_rdata = dm_done ? mem_rdata : '0;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dmReq & ~dm_done;

`ifdef MEM_ARB_CHECK_EN
  logic busy;
  assign busy = (state == ISSUE) || (state == WAIT);

  mem_arb_chk #(
    .AW(AW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .dmRd     (dm_rd),
    .dmWr     (dm_wr),
    .ifReq    (if_req),
    .ifAddr   (if_addr),
    .dmAddr   (dm_addr),
    .busy     (busy),
    .owner    (owner),
    .grantAddr(mem_addr),
    .err      (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LAT=2 main instance, LAT=3 for the write case).
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
`ifdef MEM_ARB_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  // LAT=2 instance
  logic          ifReq = 0, dmRd = 0, dmWr = 0, halt = 0;
  logic [AW-1:0] ifAddr = '0, dmAddr = '0;
  logic [DW-1:0] dmWdata = '0, memRdata = '0;
  logic [DW-1:0] ifRdata, dmRdata, memWdata;
  logic [AW-1:0] memAddr;
  logic          ifDone, ifStall, dmDone, dmStall, memEn, memWr, err;

  // LAT=3 instance
  logic          wDmWr = 0;
  logic [AW-1:0] wDmAddr = '0;
  logic [DW-1:0] wDmWdata = '0;
  logic [DW-1:0] wIfRdata, wDmRdata, wMemWdata;
  logic [AW-1:0] wMemAddr;
  logic          wIfDone, wIfStall, wDmDone, wDmStall, wMemEn, wMemWr, wErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(2), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_done(ifDone), .if_stall(ifStall),
    .dm_rd(dmRd), .dm_wr(dmWr), .dm_addr(dmAddr), .dm_wdata(dmWdata), .dm_rdata(dmRdata),
    .dm_done(dmDone), .dm_stall(dmStall), .halt(halt),
    .mem_en(memEn), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .err(err)
  );

  mem_arbiter #(.LAT(3), .AW(AW), .DW(DW)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_rdata(wIfRdata), .if_done(wIfDone), .if_stall(wIfStall),
    .dm_rd(1'b0), .dm_wr(wDmWr), .dm_addr(wDmAddr), .dm_wdata(wDmWdata), .dm_rdata(wDmRdata),
    .dm_done(wDmDone), .dm_stall(wDmStall), .halt(1'b0),
    .mem_en(wMemEn), .mem_wr(wMemWr), .mem_addr(wMemAddr), .mem_wdata(wMemWdata),
    .mem_rdata(16'h0000), .err(wErr)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    #2;
    checkVal("rst_mem_en", 32'(memEn), 0);
    checkVal("rst_mem_wr", 32'(memWr), 0);
    checkVal("rst_mem_addr", 32'(memAddr), 0);
    checkVal("rst_mem_wdata", 32'(memWdata), 0);
    checkVal("rst_if_done", 32'(ifDone), 0);
    checkVal("rst_dm_done", 32'(dmDone), 0);
    checkVal("rst_err", 32'(err), 0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();

    // Fetch read, LAT=2
    ifReq = 1; ifAddr = 16'h0010; memRdata = 16'hA5A5;
    for (int c = 0; c < 4; c++) begin
      midCycle();
      checkVal($sformatf("f_mem_en_c%0d", c), 32'(memEn), 32'(c == 1));
      checkVal($sformatf("f_if_done_c%0d", c), 32'(ifDone), 32'(c == 3));
      checkVal($sformatf("f_if_stall_c%0d", c), 32'(ifStall), 32'(c < 3));
      checkVal($sformatf("f_dm_done_c%0d", c), 32'(dmDone), 0);
      if (c == 1) begin
        checkVal("f_mem_addr", 32'(memAddr), 32'h0010);
        checkVal("f_mem_wr", 32'(memWr), 0);
      end
      if (c == 3) checkVal("f_if_rdata", 32'(ifRdata), 32'hA5A5);
      nextCycle();
    end
    ifReq = 0;
    midCycle();
    checkVal("f_if_done_after", 32'(ifDone), 0);
    nextCycle();

    // Simultaneous fetch and data read: data first, fetch issued at cycle 5
    ifReq = 1; ifAddr = 16'h0040; dmRd = 1; dmAddr = 16'h0100; memRdata = 16'hBEEF;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) dmRd = 0;
      midCycle();
      checkVal($sformatf("s_mem_en_c%0d", c), 32'(memEn), 32'(c == 1 || c == 5));
      checkVal($sformatf("s_dm_done_c%0d", c), 32'(dmDone), 32'(c == 3));
      checkVal($sformatf("s_if_done_c%0d", c), 32'(ifDone), 32'(c == 7));
      checkVal($sformatf("s_if_stall_c%0d", c), 32'(ifStall), 32'(c != 7));
      if (c == 1) checkVal("s_mem_addr_dm", 32'(memAddr), 32'h0100);
      if (c == 3) checkVal("s_dm_rdata", 32'(dmRdata), 32'hBEEF);
      if (c == 5) checkVal("s_mem_addr_if", 32'(memAddr), 32'h0040);
      nextCycle();
    end
    ifReq = 0;
    nextCycle();

    // Data write on the LAT=3 instance
    wDmWr = 1; wDmAddr = 16'h0020; wDmWdata = 16'h1234;
    for (int c = 0; c < 5; c++) begin
      midCycle();
      checkVal($sformatf("w_mem_en_c%0d", c), 32'(wMemEn), 32'(c == 1));
      checkVal($sformatf("w_dm_done_c%0d", c), 32'(wDmDone), 32'(c == 4));
      checkVal($sformatf("w_if_done_c%0d", c), 32'(wIfDone), 0);
      if (c == 1) begin
        checkVal("w_mem_wr", 32'(wMemWr), 1);
        checkVal("w_mem_wdata", 32'(wMemWdata), 32'h1234);
        checkVal("w_mem_addr", 32'(wMemAddr), 32'h0020);
      end
      nextCycle();
    end
    wDmWr = 0;
    nextCycle();

    // Halt gating; data read raised at cycle 10 is still served
    halt = 1; ifReq = 1; ifAddr = 16'h0060;
    for (int c = 0; c < 14; c++) begin
      if (c == 10) begin dmRd = 1; dmAddr = 16'h0200; end
      midCycle();
      checkVal($sformatf("h_mem_en_c%0d", c), 32'(memEn), 32'(c == 11));
      checkVal($sformatf("h_dm_done_c%0d", c), 32'(dmDone), 32'(c == 13));
      checkVal($sformatf("h_if_stall_c%0d", c), 32'(ifStall), 1);
      checkVal($sformatf("h_if_done_c%0d", c), 32'(ifDone), 0);
      nextCycle();
    end
    dmRd = 0; ifReq = 0; halt = 0;
    nextCycle();

    // Reset during WAIT, then pending fetch regranted from IDLE
    ifReq = 1; ifAddr = 16'h0030;
    midCycle();
    nextCycle();
    midCycle();
    checkVal("r_mem_en_issue", 32'(memEn), 1);
    nextCycle();
    rst = 0;
    #1;
    checkVal("r_mem_addr_async", 32'(memAddr), 0);
    checkVal("r_mem_en_async", 32'(memEn), 0);
    checkVal("r_mem_wr_async", 32'(memWr), 0);
    nextCycle();
    rst = 1;
    for (int c = 3; c < 7; c++) begin
      midCycle();
      checkVal($sformatf("r_if_done_c%0d", c), 32'(ifDone), 32'(c == 6));
      checkVal($sformatf("r_mem_en_c%0d", c), 32'(memEn), 32'(c == 4));
      if (c == 4) checkVal("r_mem_addr", 32'(memAddr), 32'h0030);
      nextCycle();
    end
    ifReq = 0;
    nextCycle();

    // Dual rd/wr: served as a write, err sticky when the checker is present
    dmRd = 1; dmWr = 1; dmAddr = 16'h0050; dmWdata = 16'h5555;
    for (int c = 0; c < 4; c++) begin
      midCycle();
      checkVal($sformatf("d_err_c%0d", c), 32'(err), 32'((c >= 1) ? CHK : 1'b0));
      checkVal($sformatf("d_dm_done_c%0d", c), 32'(dmDone), 32'(c == 3));
      if (c == 1) begin
        checkVal("d_mem_en", 32'(memEn), 1);
        checkVal("d_mem_wr", 32'(memWr), 1);
        checkVal("d_mem_wdata", 32'(memWdata), 32'h5555);
      end
      nextCycle();
    end
    dmRd = 0; dmWr = 0;
    nextCycle();
    midCycle();
    checkVal("d_err_sticky", 32'(err), 32'(CHK));
    nextCycle();
    rst = 0;
    #1;
    checkVal("d_err_reset", 32'(err), 0);
    nextCycle();
    rst = 1;
    nextCycle();

    // Unaligned data address
    dmRd = 1; dmAddr = 16'h0003;
    for (int c = 0; c < 4; c++) begin
      midCycle();
      checkVal($sformatf("u_err_c%0d", c), 32'(err), 32'((c >= 2) ? CHK : 1'b0));
      if (c == 1) checkVal("u_mem_addr", 32'(memAddr), 32'h0003);
      if (c == 3) checkVal("u_dm_done", 32'(dmDone), 1);
      nextCycle();
    end
    dmRd = 0;
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
